// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, fetch-buffer entry layout, reset PC.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INSTR_W    = 32;
  localparam int IF_ENTRY_W = XLEN + INSTR_W;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetch-buffer slot: the PC travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between fetch and decode.
// Flush empties it in one cycle; head_data is a combinational view of the
// oldest slot so a pushed word is visible right after the edge that wrote it.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [IF_ENTRY_W-1:0]       push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [$clog2(DEPTH):0]      count,
  output logic [IF_ENTRY_W-1:0]       head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IF_ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  // Slot storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; flush beats push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, requests words from instruction memory,
// buffers {pc, instr} for decode and restarts on a branch/jump redirect.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [INSTR_W-1:0]  imem_data_i,
  input  logic                redirect_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  output logic                instr_valid_o,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     pc_plus4_o,
  input  logic                instr_ready_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              run_reg;
  logic [XLEN-1:0]   fetch_pc_reg;
  logic [XLEN-1:0]   fetch_pc_next;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              accept;
  logic              pop;
  if_entry_t         push_entry;
  if_entry_t         head_entry;
  logic [IF_ENTRY_W-1:0] head_data;

  // Request depends only on registered state, so it never glitches with
  // ack/redirect; it stays up until the word is taken or the PC is redirected.
  assign full        = (count == CNT_W'(DEPTH));
  assign imem_req_o  = run_reg & ~full;
  assign imem_addr_o = fetch_pc_reg;

  // A redirect discards whatever memory returns in the same cycle.
  assign accept = imem_req_o & imem_ack_i & ~redirect_i;
  assign pop    = instr_valid_o & instr_ready_i;

  assign push_entry.pc    = fetch_pc_reg;
  assign push_entry.instr = imem_data_i;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (count),
    .head_data (head_data)
  );

  assign head_entry    = if_entry_t'(head_data);
  assign instr_valid_o = (count != '0);
  assign instr_o       = head_entry.instr;
  assign pc_o          = head_entry.pc;
  assign pc_plus4_o    = head_entry.pc + 32'd4;

  // Next fetch PC: redirect target first, else advance by one word on accept.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_i) begin
      fetch_pc_next = word_align(redirect_pc_i);
    end else if (accept) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
  end

  // Fetch PC and run flag; run comes up on the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_reg <= word_align(RESET_PC);
      run_reg      <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      run_reg      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected {pc, instr}.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ready = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic        run_m = 1'b0;
  logic [31:0] pc_m = 32'h0;

  always #5 clk = ~clk;

  // Instruction memory model: contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  assign imem_data = mem_word(imem_addr);

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .instr_ready_i (instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs against the model, drive inputs, advance.
  task automatic step(input logic ack, input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    logic exp_req;
    logic exp_valid;
    exp_t head;
    exp_req   = run_m && (sb.size() < DEPTH);
    exp_valid = (sb.size() != 0);
    chk("req", 32'(imem_req), 32'(exp_req));
    chk("addr", imem_addr, pc_m);
    chk("valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = sb[0];
      chk("head_pc", pc, head.pc);
      chk("head_instr", instr, head.instr);
      chk("head_pc_plus4", pc_plus4, head.pc + 32'd4);
    end
    imem_ack    = ack;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    $display("step t=%0t ack=%0b rdy=%0b redir=%0b addr=%h valid=%0b pc=%h",
             $time, ack, rdy, redir, imem_addr, instr_valid, pc);
    if (redir) begin
      sb.delete();
      pc_m = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) begin
        void'(sb.pop_front());
      end
      if (exp_req && ack) begin
        sb.push_back('{pc: pc_m, instr: mem_word(pc_m)});
        pc_m = pc_m + 32'd4;
      end
    end
    run_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;

    // Streaming with ack and ready high
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Fill to full with ready low, then a single pop re-opens requests
    step(1'b0, 1'b0, 1'b1, 32'h0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_req_low", 32'(imem_req), 32'd0);
    chk("full_head_pc", pc, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("refill_req", 32'(imem_req), 32'd1);
    chk("refill_addr", imem_addr, 32'h10);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Ack delayed three cycles per request
    repeat (3) begin
      repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle as the ack of 0x8
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_pre_addr", imem_addr, 32'h8);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_head_pc", pc, 32'h100);
    chk("redir_head_pc_plus4", pc_plus4, 32'h104);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

    // Address wrap at the top of memory
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr2", imem_addr, 32'h0);
    chk("wrap_head_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset with three entries buffered
    step(1'b0, 1'b0, 1'b1, 32'h40);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    sb.delete();
    run_m = 1'b0;
    pc_m  = 32'h0;
    @(negedge clk);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that sits directly upstream of the decoder / register-file read in the CPU datapath. Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. Decode consumes them over a valid/ready handshake. A branch/jump redirect flushes the buffer and restarts fetch at the new target.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word address of the request.
- imem_ack_i  in  1  memory accepts the request; data valid in the same cycle.
- imem_data_i  in  32  instruction word, sampled when imem_req_o & imem_ack_i.
- redirect_i  in  1  branch/jump taken; flush and refetch.
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  FIFO head holds a valid instruction.
- instr_o  out  32  head instruction word.
- pc_o  out  32  head PC.
- pc_plus4_o  out  32  pc_o + 4, mod 2^32.
- instr_ready_i  in  1  decode accepts the head.

## Operation
- State: fetch_pc (32b), run flag, FIFO of {pc, instr}, count (0..DEPTH).
- run is cleared by reset and set on the first clock edge after reset release.
- imem_req_o = run & (count != DEPTH). It depends only on registered state, never on inputs.
- imem_addr_o = fetch_pc. Bits [1:0] are always 0.
- Accept = imem_req_o & imem_ack_i & !redirect_i.
  - Push {fetch_pc, imem_data_i}.
  - fetch_pc += 4, wrapping 0xFFFF_FFFC → 0x0000_0000.
- Once raised, imem_req_o and imem_addr_o stay stable until ack or redirect.
  - count only rises on accept, so full cannot occur while a request is pending.
- Pop = instr_valid_o & instr_ready_i. Removes the head.
- instr_valid_o = (count != 0).
- instr_o and pc_o show the head slot. Their contents when invalid are don't-care, except after reset, where they are 0.
- Redirect (priority over all other events):
  - FIFO emptied (count ← 0).
  - fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - A same-cycle ack'd word is discarded.
  - A same-cycle pop is irrelevant.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty is impossible, since valid is low.
  - Push when full is impossible, since req is low.
- No bypass: a word accepted at edge N is visible at the head after edge N.
- Reset mid-operation clears everything asynchronously. Any in-flight handshake is abandoned.

## Timing
- Reset values:
  - imem_req_o 0
  - imem_addr_o RESET_PC
  - instr_valid_o 0
  - instr_o 0
  - pc_o 0
  - pc_plus4_o 4
- First imem_req_o: the cycle after the first clock edge following rst_i rising.
- Fetch latency: ack in cycle N → instr_valid_o in cycle N+1.
- Throughput: with ack tied high and ready high, one instruction per cycle steady-state.
- Redirect latency: redirect_i in cycle N → imem_addr_o = target in cycle N+1, and instr_valid_o = 0 in cycle N+1.
  - With immediate ack, the first target instruction is valid in cycle N+2.
- Full: count == DEPTH forces req low. A pop in cycle N re-raises req in cycle N+1.

## Structure
- Shared package cpu_pkg holds:
  - XLEN = 32, INSTR_W = 32
  - IF_ENTRY_W = XLEN + INSTR_W
  - default RESET_PC
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, head_data, async active-low reset.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Top level holds fetch_pc, the run flag, the handshake logic and the pc_plus4 adder.

## Test plan
- Reset release, ack=1, ready=1:
  - req rises one cycle after release.
  - Addresses 0, 4, 8, … every cycle.
  - pc_o sequence 0, 4, 8 starting one cycle after the first ack.
  - instr_o equals the memory model contents.
- ready=0, ack=1, DEPTH=4:
  - Exactly 4 accepts (0x0–0xC), then req low.
  - Raise ready for one cycle → head 0x0 popped, req high the next cycle, address 0x10.
- ack delayed 3 cycles per request:
  - imem_addr_o held constant while waiting.
  - Each instruction valid exactly one cycle after its ack.
- Redirect to 0x0000_0103 in the same cycle as an ack of 0x8:
  - Word for 0x8 dropped, FIFO empty.
  - Next address 0x100.
  - Next pc_o 0x100, pc_plus4_o 0x104.
- Redirect to 0xFFFF_FFF8, ack=1, ready=1:
  - Addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - pc_plus4_o at head 0xFFFF_FFFC is 0x0.
- Assert rst_i low mid-stream with FIFO holding 3 entries:
  - instr_valid_o and imem_req_o go 0 immediately, before the next clock edge.
  - After release, fetch restarts at RESET_PC.
